// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scan controller for a 12-key keypad behind a 12:1 multiplexer. Keys 0-9
// are the digits, code 10 is star and code 11 is sharp. The controller steps
// the mux select through the keys, samples the mux output after a settle
// period, debounces every key independently and queues key events in a
// small FIFO read out through a valid/ready handshake.
//
// Optional feature macro: KEYPAD_SCAN_RELEASE_EVT_EN
//   defined   : release (1->0) transitions are queued as well, key_rel
//               carries the event type and FIFO entries are 5 bits wide.
//   undefined : only press events are queued, key_rel is tied to 0 and
//               FIFO entries are 4 bits wide.
//
// Parameters:
//   SETTLE_CYC  cycles the select is held before sampling (min 1)
//   DEB_CNT     consecutive disagreeing samples to flip a key (1..7)
//   FIFO_DEPTH  event queue depth, power of 2, min 2
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   scan_en    in   1 = scan runs, 0 = park after the current key
//   B_sel      out  [3:0] mux select (0..11 only)
//   D_mux      in   selected key level (1 = pressed)
//   key_code   out  [3:0] code of the event at the FIFO head
//   key_rel    out  head event is a release
//   key_valid  out  FIFO non-empty
//   key_ready  in   consumer accepts the head event
//   ovf        out  sticky: an event was dropped on a full FIFO
//   ovf_clr    in   synchronous clear of ovf
//   key_state  out  [11:0] debounced level of every key
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC = 4,
    parameter int DEB_CNT    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        scan_en,
    output logic [3:0]  B_sel,
    input  logic        D_mux,
    output logic [3:0]  key_code,
    output logic        key_rel,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic [11:0] key_state
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [2:0] DEB_LAST = 3'(DEB_CNT - 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
`ifdef KEYPAD_SCAN_RELEASE_EVT_EN
    localparam int EW = 5;
`else
    localparam int EW = 4;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [SW-1:0]  settle_cnt;
    logic [2:0]     deb_cnt [12];

    logic           sel_stable;
    logic [2:0]     sel_cnt;
    logic           flip;
    logic           push;
    logic [EW-1:0]  push_data;

    logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [EW-1:0]  head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           pop;
    logic           accept;

    // Next-state logic. SAMPLE is always reached from SETTLE, so dropping
    // scan_en only takes effect once the current key has been sampled.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (scan_en) state_next = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE:  state_next = scan_en ? SETTLE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The settle counter runs only inside SETTLE and is zero on every entry.
    // The select advances at the end of SAMPLE and holds everywhere else.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            settle_cnt <= '0;
            B_sel      <= 4'd0;
        end else begin
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end
            if (state == SAMPLE) begin
                B_sel <= (B_sel == 4'd11) ? 4'd0 : B_sel + 4'd1;
            end
        end
    end

    // Debounce state of the currently selected key and the flip decision.
    // A flip happens when this disagreeing sample is the DEB_CNT-th in a row.
    always_comb begin
        sel_stable = 1'b0;
        sel_cnt    = 3'd0;
        for (int n = 0; n < 12; n++) begin
            if (B_sel == 4'(n)) begin
                sel_stable = key_state[n];
                sel_cnt    = deb_cnt[n];
            end
        end
        flip = (state == SAMPLE) && (D_mux != sel_stable) && (sel_cnt == DEB_LAST);
`ifdef KEYPAD_SCAN_RELEASE_EVT_EN
        // A flip of a key that was stable-high is a release.
        push      = flip;
        push_data = {sel_stable, B_sel};
`else
        push      = flip && !sel_stable;
        push_data = B_sel;
`endif
    end

    // Per-key debounce counters and stable bits; only the selected key is
    // touched, and only during SAMPLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_state <= 12'd0;
            for (int n = 0; n < 12; n++) begin
                deb_cnt[n] <= 3'd0;
            end
        end else begin
            for (int n = 0; n < 12; n++) begin
                if ((state == SAMPLE) && (B_sel == 4'(n))) begin
                    if (D_mux == key_state[n]) begin
                        deb_cnt[n] <= 3'd0;
                    end else if (flip) begin
                        key_state[n] <= ~key_state[n];
                        deb_cnt[n]   <= 3'd0;
                    end else begin
                        deb_cnt[n] <= deb_cnt[n] + 3'd1;
                    end
                end
            end
        end
    end

    // A push into a full FIFO is still accepted when the head is popped in
    // the same cycle: the freed slot is the one being written.
    assign key_valid = (count != '0);
    assign full      = (count == FIFO_FULL);
    assign pop       = key_valid && key_ready;
    assign accept    = push && (!full || pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new overflow takes priority over a clear in the same cycle.
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Head outputs come straight from storage registers; the head slot is
    // never overwritten while it is waiting for key_ready.
    assign head     = fifo_mem[rd_ptr];
    assign key_code = head[3:0];
`ifdef KEYPAD_SCAN_RELEASE_EVT_EN
    assign key_rel  = head[4];
`else
    assign key_rel  = 1'b0;
`endif

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scan controller for the 12-key keypad multiplexer. Keys 0-9 are the digit keys, code 10 is the star key and code 11 is the sharp key.
- Drives the mux 4-bit select, samples the single mux output and debounces each key independently.
- Detected key events are queued in a small FIFO with a valid/ready handshake towards the launchpad sequencer logic.

Parameters:
- SETTLE_CYC, 4: cycles the select is held before the mux output is sampled (min 1).
- DEB_CNT, 3: consecutive disagreeing samples needed to flip a key's debounced state (min 1, max 7).
- FIFO_DEPTH, 4: event queue entries; must be a power of 2, min 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- scan_en  in  1  1 = scanning runs; 0 = scanner parks after finishing the current key.
- B_sel  out  4  select driven to the 12:1 key mux.
- D_mux  in  1  selected key level from the mux (1 = pressed).
- key_code  out  4  code of the event at the FIFO head.
- key_rel  out  1  1 = head event is a release (see Optional Feature).
- key_valid  out  1  FIFO non-empty.
- key_ready  in  1  consumer accepts the head event when key_valid=1 and key_ready=1.
- ovf  out  1  sticky flag: an event was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of ovf.
- key_state  out  12  debounced level of every key; bit n = code n.

Behaviour:
- Reset values: B_sel=0, key_code=0, key_rel=0, key_valid=0, ovf=0, key_state=0. All debounce counters cleared, FIFO emptied, FSM in IDLE.
- A reset asserted mid-scan aborts immediately and discards queued events.
- FSM states are IDLE, SETTLE and SAMPLE.
- IDLE:
  - B_sel holds its last value.
  - When scan_en=1, go to SETTLE and clear the settle counter.
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles with B_sel stable, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Register D_mux for key n = B_sel and update key n's debounce logic.
  - Advance B_sel with 11→0 wrap-around.
  - Go to SETTLE if scan_en=1, otherwise IDLE.
- Select range and scan timing:
  - Codes 12-15 are never driven.
  - Each key occupies SETTLE_CYC+1 cycles. A full scan takes 12*(SETTLE_CYC+1) cycles, i.e. 60 cycles at defaults.
- Debounce, per key: a 3-bit counter plus a stable bit.
  - If the sample equals the stable bit, clear the counter.
  - Otherwise increment the counter. When it reaches DEB_CNT, toggle the stable bit, clear the counter and generate an event.
  - A key held from the start of scanning is therefore detected on its DEB_CNT-th SAMPLE.
- Events:
  - A 0→1 toggle generates a press event {code=n, rel=0}.
  - A 1→0 toggle generates a release event only when the optional feature is enabled.
  - At most one event is generated per cycle, and only in SAMPLE.
- FIFO:
  - Synchronous, with registered outputs.
  - A pushed event appears on key_code/key_valid on the next cycle when the FIFO was empty.
  - Pop happens when key_valid && key_ready.
  - Push and pop in the same cycle are both honoured, including when full; count is unchanged.
  - Push when full with no pop: the event is dropped, ovf is set, and key_state still updates.
  - When ovf_clr and a new overflow occur in the same cycle, the set wins.
- key_code and key_rel hold stable while key_valid=1 and key_ready=0.
- scan_en deassertion never truncates a SETTLE: the current key completes its SAMPLE before the FSM parks.

Optional Feature:
- Macro: KEYPAD_SCAN_RELEASE_EVT_EN.
- Defined: 1→0 debounced transitions push {code=n, rel=1}, and the key_rel output reflects the FIFO entry.
- Undefined: only press events are queued, key_rel is tied to 0, and the FIFO entry width is 4 bits.

Test Plan:
- Reset, then scan_en=1 with all keys 0:
  - B_sel sequence 0,1,…,11,0 with each value held 5 cycles.
  - key_valid stays 0.
- D_mux=1 only while B_sel=3 (press key 3), key_ready=1:
  - key_state[3] rises at the 3rd SAMPLE of key 3 (cycle 3*60-60+19=139 after scan start).
  - One event, key_code=3, key_valid pulses 1 cycle.
- Key 0 glitch pressed for only 2 consecutive scans, then released:
  - No event, key_state[0] stays 0.
- key_ready=0 with 5 distinct keys pressed (codes 0,1,2,10,11):
  - FIFO holds 0,1,2,10 and code 11 is dropped, so ovf=1.
  - Raising ovf_clr clears ovf.
  - Draining returns 0,1,2,10 in order.
- Assert RST mid-SETTLE while the FIFO holds 2 events:
  - All outputs reset immediately and B_sel=0.
  - Scanning restarts at key 0 after RST falls.
- With KEYPAD_SCAN_RELEASE_EVT_EN defined, press then release key 11 (sharp):
  - Events {11,rel=0} then {11,rel=1}.
  - Without the macro, only {11,0} is queued.
